// File: rtl/wts_pkg.sv
// Shared definitions for the multi-channel wave-table tone generator.
//   - length-code constants (2-bit per-channel wave length selector)
//   - len_log2(): maps a length code to log2 of the wave length, saturating at addr_w
//   - slot_width(): width of a channel index for a given channel count
//   - default configuration and SLOT_W for that default
package wts_pkg;

    localparam logic [1:0] LEN_CODE_QUARTER = 2'd0;  // L = 2^(ADDR_W-2)
    localparam logic [1:0] LEN_CODE_HALF    = 2'd1;  // L = 2^(ADDR_W-1)
    localparam logic [1:0] LEN_CODE_FULL    = 2'd2;  // L = 2^ADDR_W
    localparam logic [1:0] LEN_CODE_SAT     = 2'd3;  // saturates to the full length

    localparam int unsigned DEF_CHANNELS = 5;
    localparam int unsigned DEF_FREQ_W   = 12;
    localparam int unsigned DEF_ADDR_W   = 7;
    localparam int unsigned SLOT_W       = $clog2(DEF_CHANNELS);

    // log2(L) = min(addr_w - 2 + code, addr_w)
    function automatic int unsigned len_log2(input logic [1:0] code, input int unsigned addr_w);
        int unsigned l;
        l = addr_w - 32'd2 + 32'(code);
        return (l > addr_w) ? addr_w : l;
    endfunction

    function automatic int unsigned slot_width(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/wts_tone_step.sv
// Combinational next-state for one tone channel.
// Inputs : cnt, addr, stopped   - current channel state
//          reload               - frequency counter reload value
//          len_code             - wave length code
//          one_shot             - 1 = stop at end of wave
//          restart              - pending or live restart request for this channel
// Outputs: cnt_next, addr_next, stopped_next - next channel state
//          end_set, end_clr     - end flag set / clear strobes
//          half_timing          - half-period pulse for this service
module wts_tone_step
    import wts_pkg::*;
#(
    parameter int unsigned FREQ_W = 12,
    parameter int unsigned ADDR_W = 7
) (
    input  logic [FREQ_W-1:0] cnt,
    input  logic [ADDR_W-1:0] addr,
    input  logic              stopped,
    input  logic [FREQ_W-1:0] reload,
    input  logic [1:0]        len_code,
    input  logic              one_shot,
    input  logic              restart,
    output logic [FREQ_W-1:0] cnt_next,
    output logic [ADDR_W-1:0] addr_next,
    output logic              stopped_next,
    output logic              end_set,
    output logic              end_clr,
    output logic              half_timing
);

    int unsigned       log2_len;
    logic [ADDR_W-1:0] len_mask;   // L - 1
    logic [ADDR_W-1:0] half_mask;  // L/2 - 1

    always_comb begin
        log2_len = len_log2(len_code, ADDR_W);
        len_mask = '0;
        for (int unsigned i = 0; i < ADDR_W; i++) begin
            len_mask[i] = (i < log2_len);
        end
        half_mask = len_mask >> 1;
    end

    always_comb begin
        cnt_next     = cnt;
        addr_next    = addr;
        stopped_next = stopped;
        end_set      = 1'b0;
        end_clr      = 1'b0;
        half_timing  = 1'b0;

        if (restart) begin
            cnt_next     = reload;
            addr_next    = '0;
            stopped_next = 1'b0;
            end_clr      = 1'b1;
        end else if (stopped) begin
            // hold everything until the next restart
        end else if (cnt == '0) begin
            cnt_next    = reload;
            half_timing = ((addr & half_mask) == '0);
            // Masking the pre-update address lets a shortened length take effect at once.
            if (one_shot && ((addr & len_mask) == len_mask)) begin
                addr_next    = len_mask;
                stopped_next = 1'b1;
                end_set      = 1'b1;
            end else begin
                addr_next = (addr + ADDR_W'(1)) & len_mask;
            end
        end else begin
            cnt_next = cnt - FREQ_W'(1);
        end
    end

endmodule

// File: rtl/wts_tone_generator_mc.sv
// Time-multiplexed wave-table tone generator: one shared step datapath serves
// CHANNELS voices, one channel slot per active pulse.
// Ports:
//   clk, nreset          - clock, synchronous active-low reset
//   active               - service strobe; services channel at the slot pointer
//   address_reset        - per-channel restart request (latched until serviced)
//   reg_wave_length      - per-channel 2-bit length code
//   reg_frequency_count  - per-channel counter reload value
//   reg_one_shot         - per-channel one-shot enable
//   out_valid            - one-clk pulse after each service
//   out_slot             - serviced channel index
//   wave_address         - post-update wave address of out_slot
//   half_timing          - half-period pulse of out_slot
//   end_flag             - sticky per-channel one-shot completion flags
module wts_tone_generator_mc
    import wts_pkg::*;
#(
    parameter int unsigned CHANNELS = 5,
    parameter int unsigned FREQ_W   = 12,
    parameter int unsigned ADDR_W   = 7,
    localparam int unsigned SlotW   = slot_width(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         active,
    input  logic [CHANNELS-1:0]          address_reset,
    input  logic [2*CHANNELS-1:0]        reg_wave_length,
    input  logic [FREQ_W*CHANNELS-1:0]   reg_frequency_count,
    input  logic [CHANNELS-1:0]          reg_one_shot,
    output logic                         out_valid,
    output logic [SlotW-1:0]             out_slot,
    output logic [ADDR_W-1:0]            wave_address,
    output logic                         half_timing,
    output logic [CHANNELS-1:0]          end_flag
);

    logic [FREQ_W-1:0] cnt_q  [CHANNELS];
    logic [ADDR_W-1:0] addr_q [CHANNELS];
    logic [CHANNELS-1:0] stopped_q;
    logic [CHANNELS-1:0] pending_q;
    logic [CHANNELS-1:0] end_flag_q;
    logic [SlotW-1:0]    slot_q;
    logic [SlotW-1:0]    slot_next;

    logic                out_valid_q;
    logic [SlotW-1:0]    out_slot_q;
    logic [ADDR_W-1:0]   wave_address_q;
    logic                half_timing_q;

    // Selected channel (mux)
    logic [FREQ_W-1:0] sel_cnt;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_stopped;
    logic [FREQ_W-1:0] sel_reload;
    logic [1:0]        sel_len_code;
    logic              sel_one_shot;
    logic              sel_restart;

    // Step results
    logic [FREQ_W-1:0] step_cnt;
    logic [ADDR_W-1:0] step_addr;
    logic              step_stopped;
    logic              step_end_set;
    logic              step_end_clr;
    logic              step_half;

    always_comb begin
        sel_cnt      = '0;
        sel_addr     = '0;
        sel_stopped  = 1'b0;
        sel_reload   = '0;
        sel_len_code = '0;
        sel_one_shot = 1'b0;
        sel_restart  = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (slot_q == SlotW'(c)) begin
                sel_cnt      = cnt_q[c];
                sel_addr     = addr_q[c];
                sel_stopped  = stopped_q[c];
                sel_reload   = reg_frequency_count[FREQ_W*c +: FREQ_W];
                sel_len_code = reg_wave_length[2*c +: 2];
                sel_one_shot = reg_one_shot[c];
                // A request arriving on the service clk is honoured immediately.
                sel_restart  = pending_q[c] | address_reset[c];
            end
        end
    end

    always_comb begin
        slot_next = (slot_q == SlotW'(CHANNELS - 1)) ? '0 : slot_q + SlotW'(1);
    end

    wts_tone_step #(
        .FREQ_W (FREQ_W),
        .ADDR_W (ADDR_W)
    ) u_step (
        .cnt          (sel_cnt),
        .addr         (sel_addr),
        .stopped      (sel_stopped),
        .reload       (sel_reload),
        .len_code     (sel_len_code),
        .one_shot     (sel_one_shot),
        .restart      (sel_restart),
        .cnt_next     (step_cnt),
        .addr_next    (step_addr),
        .stopped_next (step_stopped),
        .end_set      (step_end_set),
        .end_clr      (step_end_clr),
        .half_timing  (step_half)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                cnt_q[c]  <= '0;
                addr_q[c] <= '0;
            end
            stopped_q      <= '0;
            pending_q      <= '0;
            end_flag_q     <= '0;
            slot_q         <= '0;
            out_valid_q    <= 1'b0;
            out_slot_q     <= '0;
            wave_address_q <= '0;
            half_timing_q  <= 1'b0;
        end else begin
            out_valid_q <= active;
            if (active) begin
                slot_q         <= slot_next;
                out_slot_q     <= slot_q;
                wave_address_q <= step_addr;
                half_timing_q  <= step_half;
            end
            // Demux: only the serviced channel takes the step results.
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (active && (slot_q == SlotW'(c))) begin
                    cnt_q[c]     <= step_cnt;
                    addr_q[c]    <= step_addr;
                    stopped_q[c] <= step_stopped;
                    pending_q[c] <= 1'b0;
                    if (step_end_clr) begin
                        end_flag_q[c] <= 1'b0;
                    end else if (step_end_set) begin
                        end_flag_q[c] <= 1'b1;
                    end
                end else if (address_reset[c]) begin
                    pending_q[c] <= 1'b1;
                end
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_slot     = out_slot_q;
    assign wave_address = wave_address_q;
    assign half_timing  = half_timing_q;
    assign end_flag     = end_flag_q;

endmodule

// File: tb/tb_wts_tone_generator_mc.sv
// Scoreboard bench for wts_tone_generator_mc (CHANNELS=5, FREQ_W=12, ADDR_W=7).
// Channel setup: ch0 reload 0 code 0 loop; ch1 reload 3 code 0 loop;
// ch2 reload 0 code 0 one-shot; ch3 reload 0 code 3 loop; ch4 reload 0 code 2 loop.
// Expected addresses are closed-form in k = services since reset/restart.
module tb_wts_tone_generator_mc;

    localparam int unsigned CH = 5;
    localparam int unsigned FW = 12;
    localparam int unsigned AW = 7;
    localparam int unsigned SW = 3;

    logic               clk = 1'b0;
    logic               nreset;
    logic               active;
    logic [CH-1:0]      address_reset;
    logic [2*CH-1:0]    reg_wave_length;
    logic [FW*CH-1:0]   reg_frequency_count;
    logic [CH-1:0]      reg_one_shot;
    logic               out_valid;
    logic [SW-1:0]      out_slot;
    logic [AW-1:0]      wave_address;
    logic               half_timing;
    logic [CH-1:0]      end_flag;

    always #5 clk = ~clk;

    wts_tone_generator_mc #(
        .CHANNELS (CH),
        .FREQ_W   (FW),
        .ADDR_W   (AW)
    ) dut (
        .clk                 (clk),
        .nreset              (nreset),
        .active              (active),
        .address_reset       (address_reset),
        .reg_wave_length     (reg_wave_length),
        .reg_frequency_count (reg_frequency_count),
        .reg_one_shot        (reg_one_shot),
        .out_valid           (out_valid),
        .out_slot            (out_slot),
        .wave_address        (wave_address),
        .half_timing         (half_timing),
        .end_flag            (end_flag)
    );

    typedef struct packed {
        logic [SW-1:0] slot;
        logic [AW-1:0] addr;
        logic          half;
        logic [CH-1:0] endf;
    } exp_t;

    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int k_m[CH];
    int slot_m;
    logic [CH-1:0] pend_m;

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Address after the k-th advancing service (k >= 1)
    function automatic int exp_addr(input int c, input int k);
        case (c)
            0:       return k % 32;
            1:       return (1 + (k - 1) / 4) % 32;
            2:       return (k >= 31) ? 31 : k;
            default: return k % 128;
        endcase
    endfunction

    function automatic logic exp_half(input int c, input int k);
        case (c)
            0:       return ((k - 1) % 16) == 0;
            1:       return (((k - 1) % 4) == 0) && ((((k - 1) / 4) % 16) == 0);
            2:       return (k <= 31) && (((k - 1) % 16) == 0);
            default: return ((k - 1) % 64) == 0;
        endcase
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got out_valid=1, required no output at %0t",
                         $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("out_slot", int'(out_slot), int'(e.slot));
                check_val("wave_address", int'(wave_address), int'(e.addr));
                check_val("half_timing", int'(half_timing), int'(e.half));
                check_val("end_flag", int'(end_flag), int'(e.endf));
            end
        end
    end

    task automatic pulse(input logic [CH-1:0] rb);
        int c;
        logic rst;
        logic [CH-1:0] m;
        exp_t e;
        c   = slot_m;
        rst = pend_m[c] | rb[c];
        m   = '0;
        m[c] = 1'b1;
        pend_m = (pend_m & ~m) | (rb & ~m);
        if (rst) k_m[c] = 0;
        else     k_m[c] = k_m[c] + 1;
        e.slot = SW'(c);
        e.addr = rst ? '0 : AW'(exp_addr(c, k_m[c]));
        e.half = rst ? 1'b0 : exp_half(c, k_m[c]);
        e.endf = (k_m[2] >= 32) ? 5'b00100 : 5'b00000;
        exp_q.push_back(e);
        active        = 1'b1;
        address_reset = rb;
        @(posedge clk);
        #1;
        active        = 1'b0;
        address_reset = '0;
        slot_m        = (slot_m + 1) % CH;
    endtask

    task automatic idle_reset(input logic [CH-1:0] rb);
        address_reset = rb;
        pend_m        = pend_m | rb;
        @(posedge clk);
        #1;
        address_reset = '0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            pulse('0);
            if ((i % 7) == 6) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_out_valid"}, int'(out_valid), 0);
        check_val({tag, "_out_slot"}, int'(out_slot), 0);
        check_val({tag, "_wave_address"}, int'(wave_address), 0);
        check_val({tag, "_half_timing"}, int'(half_timing), 0);
        check_val({tag, "_end_flag"}, int'(end_flag), 0);
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) k_m[c] = 0;
        slot_m = 0;
        pend_m = '0;
    endtask

    initial begin
        nreset              = 1'b0;
        active              = 1'b0;
        address_reset       = '0;
        reg_wave_length     = {2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
        reg_frequency_count = {12'd0, 12'd0, 12'd0, 12'd3, 12'd0};
        reg_one_shot        = 5'b00100;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        nreset = 1'b1;

        // 130 rounds: ch0/ch1 loop, ch2 stops at 31, ch3/ch4 wrap 127 -> 0
        run(650);

        // Restart ch2 from an idle clk; latched until its next slot
        idle_reset(5'b00100);
        run(10);

        // Restart ch3 on the very clk it is serviced; must not repeat later
        while (slot_m != 3) pulse('0);
        pulse(5'b01000);
        run(12);

        // Let ch2 complete again so end_flag is set before the reset
        run(175);

        // Reset with active and a restart request pending on ch1
        nreset        = 1'b0;
        active        = 1'b1;
        address_reset = 5'b00010;
        @(posedge clk);
        #1;
        active        = 1'b0;
        address_reset = '0;
        check_reset_outputs("midreset");
        nreset = 1'b1;
        model_reset();
        run(10);

        repeat (3) @(posedge clk);
        #1;
        check_val("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
